// File: rtl/imem_arbiter_pkg.sv
// Shared widths and owner-tag constants for the instruction-memory arbiter.
package imem_arbiter_pkg;
  localparam int RW     = 16;  // memory address width
  localparam int I_SIZE = 32;  // instruction word width

  // Owner tags recorded per in-flight memory request
  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_AUX   = 1'b1;
endpackage

// File: rtl/imem_arbiter_tag_fifo.sv
// In-order owner-tag FIFO: one 1-bit tag per outstanding memory request.
// A push and a pop in the same cycle are legal even when full.
module imem_arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Tag storage; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/imem_arbiter.sv
// Shares one pipelined instruction-memory port between fetch (requester 0)
// and an auxiliary requester (1). Submits that cannot issue at once are held
// until they win; acks are routed back via an in-order owner-tag FIFO.
// Optional: define IMEM_ARB_RR_EN for round-robin arbitration (default is
// fixed priority with fetch winning).
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     r0_addr,
  input  logic              r0_submit,
  output logic [I_SIZE-1:0] r0_data,
  output logic              r0_ack,
  input  logic [RW-1:0]     r1_addr,
  input  logic              r1_submit,
  output logic [I_SIZE-1:0] r1_data,
  output logic              r1_ack,
  output logic [RW-1:0]     m_addr,
  output logic              m_submit,
  input  logic [I_SIZE-1:0] m_data,
  input  logic              m_ack,
  output logic              o_proto_err
);
  logic [1:0]         pend;      // request held, waiting to issue
  logic [1:0][RW-1:0] pend_addr;
  logic [1:0]         flight;    // request issued, waiting for ack
  logic [1:0]         sub, busy, acc, req, rack;
  logic [1:0][RW-1:0] addr;
  logic               win1, issue, pop, slot_free;
  logic               fifo_full, fifo_empty, head_tag;

  assign sub = {r1_submit, r0_submit};
  assign busy = pend | flight;
  // A submit is only taken when that requester has nothing outstanding
  assign acc = sub & ~busy;
  assign req = acc | pend;

  // Held address takes precedence; otherwise bypass the live address
  always_comb begin
    for (int n = 0; n < 2; n++)
      addr[n] = pend[n] ? pend_addr[n] : (n == 0 ? r0_addr : r1_addr);
  end

`ifdef IMEM_ARB_RR_EN
  logic rr_last;  // id of the requester granted most recently

  // On contention the requester not granted last wins
  always_comb begin
    win1 = req[1];
    if (req[0] && req[1]) win1 = ~rr_last;
  end

  // Track last grant; reset favours fetch on the first contention
  always_ff @(posedge i_clk) begin
    if (i_rst)      rr_last <= 1'b1;
    else if (issue) rr_last <= win1;
  end
`else
  // Fetch always wins; requester 1 only when fetch is silent
  always_comb begin
    win1 = req[1] & ~req[0];
  end
`endif

  // A slot frees up in the same cycle an ack pops the head
  assign pop       = m_ack & ~fifo_empty;
  assign slot_free = ~fifo_full | m_ack;
  assign issue     = (|req) & slot_free & ~i_rst;

  assign m_submit = issue;
  assign m_addr   = win1 ? addr[1] : addr[0];

  imem_arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (issue),
    .din   (win1 ? TAG_AUX : TAG_FETCH),
    .pop   (pop),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ack routing by head-of-FIFO owner
  assign rack[0] = pop & (head_tag == TAG_FETCH) & ~i_rst;
  assign rack[1] = pop & (head_tag == TAG_AUX)   & ~i_rst;
  assign r0_ack  = rack[0];
  assign r1_ack  = rack[1];
  assign r0_data = m_data;
  assign r1_data = m_data;

  // Per-requester hold and in-flight state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend      <= '0;
      pend_addr <= '0;
      flight    <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (issue && (win1 == n[0])) begin
          pend[n]   <= 1'b0;
          flight[n] <= 1'b1;
        end else begin
          if (acc[n]) begin
            pend[n]      <= 1'b1;
            pend_addr[n] <= addr[n];
          end
          if (rack[n]) flight[n] <= 1'b0;
        end
      end
    end
  end

  // Sticky protocol error: stray ack or submit while already busy
  always_ff @(posedge i_clk) begin
    if (i_rst) o_proto_err <= 1'b0;
    else if ((m_ack && fifo_empty) || |(sub & busy)) o_proto_err <= 1'b1;
  end
endmodule
